// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci datapath sequencer: controller state
// encoding and default datapath/count widths.
package fib_pkg;

    localparam int DATA_W = 100;
    localparam int CNT_W  = 7;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } fib_state_e;

endpackage

// File: rtl/fib_drain_timer.sv
// Loadable down-counter that times the wait between the last datapath enable
// and a stable datapath result.
module fib_drain_timer #(
    parameter int DP_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic last_o
);

    localparam int            W        = $clog2(DP_LAT + 1);
    localparam logic [W-1:0]  LOAD_VAL = W'(DP_LAT);

    logic [W-1:0] cnt_q;

    // Held at the full wait length whenever the controller is not draining,
    // so every DRAIN entry starts from a fresh count.
    always_ff @(posedge clk) begin
        if (rst || load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/fib_seq_ctrl.sv
// Sequencing controller for the iterative accumulate datapath: clear, enable
// for n cycles, wait out the datapath latency, capture and hold the result.
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int DATA_W = fib_pkg::DATA_W,
    parameter int CNT_W  = fib_pkg::CNT_W,
    parameter int DP_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  n_i,
    input  logic              abort_i,
    input  logic              ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              start_err_o,
    output logic              dp_clr_o,
    output logic              dp_en_o,
    input  logic [DATA_W-1:0] dp_y_i
);

    fib_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] result_q;
    logic              start_err_q;
    logic              dp_clr_q;
    logic              dp_en_q;

    logic              accept;
    logic              last_run;
    logic              drain_last;

    assign accept   = (state_q == IDLE) || ((state_q == DONE) && ack_i);
    assign last_run = (cnt_q == CNT_W'(1));

    if (DP_LAT > 0) begin : g_drain
        fib_drain_timer #(
            .DP_LAT (DP_LAT)
        ) u_drain_timer (
            .clk    (clk),
            .rst    (rst),
            .load_i (state_q != DRAIN),
            .last_o (drain_last)
        );
    end else begin : g_no_drain
        assign drain_last = 1'b1;
    end

    // NOTE: all state and registered outputs update with <= so every branch
    // below sees the values from the start of the cycle, not partial updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            start_err_q <= 1'b0;
            dp_clr_q    <= 1'b0;
            dp_en_q     <= 1'b0;
        end else begin
            start_err_q <= start_i && !accept;
            dp_clr_q    <= 1'b0;

            // busy_q is set exactly in CLEAR/RUN/DRAIN, the only abortable states.
            if (abort_i && busy_q) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                dp_en_q  <= 1'b0;
                dp_clr_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            cnt_q    <= n_i;
                            state_q  <= CLEAR;
                            busy_q   <= 1'b1;
                            dp_clr_q <= 1'b1;
                        end
                    end

                    CLEAR: begin
                        if (cnt_q != '0) begin
                            state_q <= RUN;
                            dp_en_q <= 1'b1;
                        end else begin
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= '0;
                        end
                    end

                    RUN: begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (last_run) begin
                            dp_en_q <= 1'b0;
                            if (DP_LAT == 0) begin
                                state_q  <= DONE;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                                result_q <= dp_y_i;
                            end else begin
                                state_q <= DRAIN;
                            end
                        end
                    end

                    DRAIN: begin
                        if (drain_last) begin
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= dp_y_i;
                        end
                    end

                    DONE: begin
                        if (ack_i) begin
                            done_q <= 1'b0;
                            if (start_i) begin
                                cnt_q    <= n_i;
                                state_q  <= CLEAR;
                                busy_q   <= 1'b1;
                                dp_clr_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        dp_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The datapath is cleared for as long as the controller is held in reset.
    assign dp_clr_o    = dp_clr_q | rst;
    assign dp_en_o     = dp_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign start_err_o = start_err_q;

    a_no_clr_while_en: assert property (@(posedge clk) disable iff (rst)
        !(dp_en_q && dp_clr_q));
    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst)
        !(busy_q && done_q));

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: two instances (DP_LAT 1 and 3) share
// stimulus and are compared every cycle against a timeline-based run model.
module tb_fib_seq_ctrl;

    localparam int DW = fib_pkg::DATA_W;
    localparam int CW = fib_pkg::CNT_W;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ack   = 1'b0;
    logic [CW-1:0] n_in  = '0;

    logic [1:0]    busy, done, start_err, dp_clr, dp_en;
    logic [DW-1:0] result [2];
    logic [DW-1:0] dp_y   [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 3;
        logic [DW-1:0] a  = '0;
        logic [DW-1:0] b  = '0;
        logic [DW-1:0] p0 = '0;
        logic [DW-1:0] p1 = '0;

        fib_seq_ctrl #(
            .DATA_W (DW),
            .CNT_W  (CW),
            .DP_LAT (L)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start_i     (start),
            .n_i         (n_in),
            .abort_i     (abort),
            .ack_i       (ack),
            .busy_o      (busy[g]),
            .done_o      (done[g]),
            .result_o    (result[g]),
            .start_err_o (start_err[g]),
            .dp_clr_o    (dp_clr[g]),
            .dp_en_o     (dp_en[g]),
            .dp_y_i      (dp_y[g])
        );

        // Fibonacci datapath: register a is the first output stage.
        always @(posedge clk) begin
            if (dp_clr[g]) begin
                a <= '0;
                b <= DW'(1);
            end else if (dp_en[g]) begin
                a <= b;
                b <= a + b;
            end
            p0 <= a;
            p1 <= p0;
        end
        assign dp_y[g] = (L == 1) ? a : p1;
    end

    // ---------------- reference model: one record per instance -------------
    int            lat [2] = '{1, 3};
    logic [DW-1:0] fib_tab [128];
    bit            has_run [2];
    bit            aborted [2];
    bit            err_q   [2];
    int            t_acc   [2];
    int            n_run   [2];
    int            abort_a [2];
    int            ack_k   [2];
    logic [DW-1:0] prev    [2];
    int            en_cnt  [2];

    function automatic int done_start(input int i);
        return (n_run[i] == 0) ? t_acc[i] + 2 : t_acc[i] + 2 + n_run[i] + lat[i];
    endfunction

    function automatic bit live(input int i, input int c);
        return has_run[i] && (!aborted[i] || c <= abort_a[i]);
    endfunction

    function automatic bit m_busy(input int i, input int c);
        return live(i, c) && c >= t_acc[i] + 1 && c < done_start(i);
    endfunction

    function automatic bit m_done(input int i, input int c);
        return has_run[i] && !aborted[i] && c >= done_start(i) && (ack_k[i] < 0 || c <= ack_k[i]);
    endfunction

    function automatic bit m_en(input int i, input int c);
        return live(i, c) && c >= t_acc[i] + 2 && c <= t_acc[i] + 1 + n_run[i];
    endfunction

    function automatic bit m_clr(input int i, input int c);
        return rst || (has_run[i] && c == t_acc[i] + 1) ||
               (has_run[i] && aborted[i] && c == abort_a[i] + 1);
    endfunction

    function automatic logic [DW-1:0] m_result(input int i, input int c);
        if (has_run[i] && !aborted[i] && c >= done_start(i)) return fib_tab[n_run[i]];
        return prev[i];
    endfunction

    always @(posedge clk) begin
        bit bz, dn, acc;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                has_run[i] = 1'b0;
                aborted[i] = 1'b0;
                err_q[i]   = 1'b0;
                prev[i]    = '0;
            end else begin
                bz  = m_busy(i, cyc);
                dn  = m_done(i, cyc);
                acc = start && ((!bz && !dn) || (dn && ack));
                if (bz && abort) begin
                    aborted[i] = 1'b1;
                    abort_a[i] = cyc;
                end
                if (dn && ack) ack_k[i] = cyc;
                if (acc) begin
                    prev[i]    = m_result(i, cyc);
                    has_run[i] = 1'b1;
                    t_acc[i]   = cyc;
                    n_run[i]   = int'(n_in);
                    aborted[i] = 1'b0;
                    ack_k[i]   = -1;
                end
                err_q[i] = start && !acc;
            end
        end
        if (rst) chk_on = 1'b1;
        cyc++;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (dp_clr[i] === 1'b1) en_cnt[i] = 0;
            else if (dp_en[i] === 1'b1) en_cnt[i]++;
            if (chk_on) begin
                check($sformatf("busy%0d", i),      DW'(busy[i]),      DW'(m_busy(i, cyc)));
                check($sformatf("done%0d", i),      DW'(done[i]),      DW'(m_done(i, cyc)));
                check($sformatf("dp_en%0d", i),     DW'(dp_en[i]),     DW'(m_en(i, cyc)));
                check($sformatf("dp_clr%0d", i),    DW'(dp_clr[i]),    DW'(m_clr(i, cyc)));
                check($sformatf("start_err%0d", i), DW'(start_err[i]), DW'(err_q[i]));
                check($sformatf("result%0d", i),    result[i],         m_result(i, cyc));
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start(input int nv, input bit with_ack);
        start = 1'b1;
        n_in  = CW'(nv);
        ack   = with_ack;
        tick();
        start = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic wait_done(input int i, input int bound, output int when);
        int k = 0;
        while (done[i] !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        if (done[i] !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_done%0d: done=%b after %0d cycles, required 1", i, done[i], bound);
        end
        when = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, w;
        bit seen;
        int r;

        fib_tab[0] = '0;
        fib_tab[1] = DW'(1);
        for (int k = 2; k < 128; k++) fib_tab[k] = fib_tab[k-1] + fib_tab[k-2];

        // Reset values, with the datapath clear asserted while in reset.
        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_busy%0d", i),   DW'(busy[i]),      DW'(0));
            check($sformatf("rst_done%0d", i),   DW'(done[i]),      DW'(0));
            check($sformatf("rst_result%0d", i), result[i],         DW'(0));
            check($sformatf("rst_err%0d", i),    DW'(start_err[i]), DW'(0));
            check($sformatf("rst_en%0d", i),     DW'(dp_en[i]),     DW'(0));
            check($sformatf("rst_clr%0d", i),    DW'(dp_clr[i]),    DW'(1));
        end
        rst = 1'b0;
        tick();

        // n=10: 10 enables, done at t+2+n+DP_LAT, result F(10)=55.
        t = cyc;
        run_start(10, 1'b0);
        wait_done(0, 40, w);
        check("n10_latency0", DW'(w - t), DW'(13));
        check("n10_result0", result[0], DW'(55));
        check("n10_en0", DW'(en_cnt[0]), DW'(10));
        wait_done(1, 40, w);
        check("n10_latency1", DW'(w - t), DW'(15));
        check("n10_result1", result[1], DW'(55));
        check("n10_en1", DW'(en_cnt[1]), DW'(10));
        ack_pulse();
        check("ack_done0", DW'(done[0]), DW'(0));
        check("ack_done1", DW'(done[1]), DW'(0));
        check("ack_keep0", result[0], DW'(55));

        // n=0: clear only, done two cycles after start, result 0.
        t = cyc;
        run_start(0, 1'b0);
        wait_done(0, 10, w);
        check("n0_latency0", DW'(w - t), DW'(2));
        wait_done(1, 10, w);
        check("n0_latency1", DW'(w - t), DW'(2));
        for (int i = 0; i < 2; i++) begin
            check($sformatf("n0_result%0d", i), result[i], DW'(0));
            check($sformatf("n0_en%0d", i), DW'(en_cnt[i]), DW'(0));
        end
        ack_pulse();

        // n=127: longest run, no count wrap.
        run_start(127, 1'b0);
        wait_done(0, 200, w);
        wait_done(1, 200, w);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("n127_result%0d", i), result[i], fib_tab[127]);
            check($sformatf("n127_en%0d", i), DW'(en_cnt[i]), DW'(127));
        end
        ack_pulse();

        // Start during RUN: one-cycle error pulse, run unaffected.
        run_start(20, 1'b0);
        tick();
        start = 1'b1;
        n_in  = CW'(3);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) check($sformatf("err_pulse%0d", i), DW'(start_err[i]), DW'(1));
        tick();
        for (int i = 0; i < 2; i++) check($sformatf("err_end%0d", i), DW'(start_err[i]), DW'(0));
        wait_done(1, 60, w);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("n20_result%0d", i), result[i], DW'(6765));
            check($sformatf("n20_en%0d", i), DW'(en_cnt[i]), DW'(20));
        end
        ack_pulse();

        // Back-to-back: n=5, then ack+start n=6 in the same DONE cycle.
        run_start(5, 1'b0);
        wait_done(0, 20, w);
        wait_done(1, 20, w);
        for (int i = 0; i < 2; i++) check($sformatf("n5_result%0d", i), result[i], DW'(5));
        run_start(6, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("b2b_clr%0d", i), DW'(dp_clr[i]), DW'(1));
            check($sformatf("b2b_done%0d", i), DW'(done[i]), DW'(0));
        end
        wait_done(1, 20, w);
        for (int i = 0; i < 2; i++) check($sformatf("n6_result%0d", i), result[i], DW'(8));
        ack_pulse();

        // Abort in the 4th RUN cycle of n=20 after a result of 55.
        run_start(10, 1'b0);
        wait_done(1, 40, w);
        ack_pulse();
        t = cyc;
        run_start(20, 1'b0);
        repeat (4) tick();
        check("abort_in_run", DW'(dp_en[0]), DW'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("abort_busy%0d", i), DW'(busy[i]), DW'(0));
            check($sformatf("abort_clr%0d", i), DW'(dp_clr[i]), DW'(1));
            check($sformatf("abort_en%0d", i), DW'(dp_en[i]), DW'(0));
        end
        tick();
        check("abort_clr_end", DW'(dp_clr[0]), DW'(0));
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (done !== 2'b00) seen = 1'b1;
        end
        check("abort_no_done", DW'(seen), DW'(0));
        for (int i = 0; i < 2; i++) check($sformatf("abort_keep%0d", i), result[i], DW'(55));

        // Reset in the middle of the DP_LAT=3 drain wait.
        t = cyc;
        run_start(4, 1'b0);
        repeat (6) tick();
        check("drain_busy1", DW'(busy[1]), DW'(1));
        check("drain_en1", DW'(dp_en[1]), DW'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("mrst_busy%0d", i), DW'(busy[i]), DW'(0));
            check($sformatf("mrst_done%0d", i), DW'(done[i]), DW'(0));
            check($sformatf("mrst_result%0d", i), result[i], DW'(0));
            check($sformatf("mrst_en%0d", i), DW'(dp_en[i]), DW'(0));
        end
        run_start(1, 1'b0);
        wait_done(0, 20, w);
        wait_done(1, 20, w);
        for (int i = 0; i < 2; i++) check($sformatf("n1_result%0d", i), result[i], DW'(1));
        ack_pulse();

        // Randomized traffic, checked every cycle by the model.
        repeat (2500) begin
            rst   = ($urandom_range(0, 599) == 0);
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 29) == 0);
            ack   = ($urandom_range(0, 3) == 0);
            r     = int'($urandom_range(0, 9));
            if (r == 0)      n_in = CW'(127);
            else if (r == 1) n_in = CW'($urandom_range(0, 127));
            else             n_in = CW'($urandom_range(0, 8));
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        ack   = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
